// File: rtl/stack_arbiter.sv
// rtl/stack_arbiter.sv - two-port arbiter sharing one operand-stack trigger/push/done port
//
// Ports:
//   clk, rst                      clock; synchronous active-high reset
//   a_trigger/a_push/a_write      port A request strobe, push(1)/pop(0), push data
//   a_read/a_done                 port A pop result (held until next pop) and completion pulse
//   b_*                           same as port A, for port B
//   stk_trigger/stk_push/stk_write  request forwarded to the stack
//   stk_read/stk_done             stack pop data and completion
//   owner                         current or last grant (0 = A, 1 = B)
//   busy                          a stack operation is in flight
//
// Build option: define STACK_ARB_ROUNDROBIN_EN to break ties in favour of the port that
// did not receive the last grant; left undefined, port A always wins a tie.
module stack_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_trigger,
    input  logic        a_push,
    input  logic [31:0] a_write,
    output logic [31:0] a_read,
    output logic        a_done,
    input  logic        b_trigger,
    input  logic        b_push,
    input  logic [31:0] b_write,
    output logic [31:0] b_read,
    output logic        b_done,
    output logic        stk_trigger,
    output logic        stk_push,
    output logic [31:0] stk_write,
    input  logic [31:0] stk_read,
    input  logic        stk_done,
    output logic        owner,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t      state;
    logic        pend_a;
    logic        pend_b;
    logic        req_push_a;
    logic        req_push_b;
    logic [31:0] req_write_a;
    logic [31:0] req_write_b;
    logic        grant_b;
    logic        complete;

    // Winner among the pending ports; only meaningful in IDLE with something pending.
    always_comb begin
`ifdef STACK_ARB_ROUNDROBIN_EN
        grant_b = pend_b && (!pend_a || !owner);
`else
        grant_b = pend_b && !pend_a;
`endif
    end

    // stk_done only counts while a request is actually outstanding.
    assign complete = ((state == ISSUE) || (state == WAIT)) && stk_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pend_a      <= 1'b0;
            pend_b      <= 1'b0;
            req_push_a  <= 1'b0;
            req_push_b  <= 1'b0;
            req_write_a <= 32'd0;
            req_write_b <= 32'd0;
            a_read      <= 32'd0;
            b_read      <= 32'd0;
            a_done      <= 1'b0;
            b_done      <= 1'b0;
            stk_trigger <= 1'b0;
            stk_push    <= 1'b0;
            stk_write   <= 32'd0;
            owner       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            stk_trigger <= 1'b0;
            a_done      <= 1'b0;
            b_done      <= 1'b0;

            // A trigger while already pending is dropped so the captured request stays intact.
            if (a_trigger && !pend_a) begin
                pend_a      <= 1'b1;
                req_push_a  <= a_push;
                req_write_a <= a_write;
            end
            if (b_trigger && !pend_b) begin
                pend_b      <= 1'b1;
                req_push_b  <= b_push;
                req_write_b <= b_write;
            end

            case (state)
                IDLE: begin
                    if (pend_a || pend_b) begin
                        owner       <= grant_b;
                        stk_push    <= grant_b ? req_push_b : req_push_a;
                        stk_write   <= grant_b ? req_write_b : req_write_a;
                        stk_trigger <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!stk_done) begin
                        state <= WAIT;
                    end
                end
                default: begin
                end
            endcase

            // stk_push still holds the granted request's direction, so it selects pop capture.
            if (complete) begin
                if (owner) begin
                    b_done <= 1'b1;
                    pend_b <= 1'b0;
                    if (!stk_push) begin
                        b_read <= stk_read;
                    end
                end else begin
                    a_done <= 1'b1;
                    pend_a <= 1'b0;
                    if (!stk_push) begin
                        a_read <= stk_read;
                    end
                end
                busy  <= 1'b0;
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_stack_arbiter.sv
// tb/tb_stack_arbiter.sv - scoreboard bench for stack_arbiter with a transaction-level reference model
module tb_stack_arbiter;
    localparam int TAB = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_trigger, a_push, b_trigger, b_push;
    logic [31:0] a_write, b_write, a_read, b_read;
    logic        a_done, b_done;
    logic        stk_trigger, stk_push, stk_done, owner, busy;
    logic [31:0] stk_write, stk_read;

    stack_arbiter dut (
        .clk(clk), .rst(rst),
        .a_trigger(a_trigger), .a_push(a_push), .a_write(a_write), .a_read(a_read), .a_done(a_done),
        .b_trigger(b_trigger), .b_push(b_push), .b_write(b_write), .b_read(b_read), .b_done(b_done),
        .stk_trigger(stk_trigger), .stk_push(stk_push), .stk_write(stk_write),
        .stk_read(stk_read), .stk_done(stk_done), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic push; logic [31:0] wr; int cyc; } grant_t;
    typedef struct { int port; logic [31:0] rd; int cyc; } done_t;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int a_done_cnt = 0;
    int b_done_cnt = 0;

    // Per-operation stack behaviour, shared by the stack responder and the model.
    int          lat_tab [TAB];
    logic [31:0] rd_tab  [TAB];

    grant_t      grant_q[$];
    done_t       done_q[$];
    logic [31:0] wr_log[$];

    // Reference model state: requests waiting per port, one operation in flight.
    bit          m_pend [2];
    bit          m_push [2];
    logic [31:0] m_data [2];
    logic [31:0] m_read [2];
    bit          m_busy = 0;
    bit          m_owner = 0;
    bit          m_cur_push = 0;
    logic [31:0] m_cur_val = 0;
    int          m_left = 0;
    int          m_k = 0;

    bit          r_busy = 0;
    int          r_left = 0;
    int          r_k = 0;
    logic [31:0] r_val = 0;

    task automatic chk(input bit ok, input string name, input string act, input string req);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("FAIL %s: actual %s required %s", name, act, req);
        end
    endtask

    // Reference model, advanced once per rising edge.
    initial begin
        bit old_pend [2];
        bit trig [2];
        bit tpush [2];
        logic [31:0] tdata [2];
        int w;
        m_pend = '{0, 0};
        m_read = '{32'd0, 32'd0};
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_pend  = '{0, 0};
                m_read  = '{32'd0, 32'd0};
                m_busy  = 0;
                m_owner = 0;
            end else begin
                old_pend = m_pend;
                trig  = '{a_trigger, b_trigger};
                tpush = '{a_push, b_push};
                tdata = '{a_write, b_write};
                if (m_busy) begin
                    if (m_left == 0) begin
                        if (!m_cur_push) m_read[m_owner] = m_cur_val;
                        done_q.push_back('{int'(m_owner), m_read[m_owner], cyc});
                        m_pend[m_owner] = 0;
                        m_busy = 0;
                    end else begin
                        m_left--;
                    end
                end else if (old_pend[0] || old_pend[1]) begin
                    if (old_pend[0] && old_pend[1]) begin
`ifdef STACK_ARB_ROUNDROBIN_EN
                        w = m_owner ? 0 : 1;
`else
                        w = 0;
`endif
                    end else begin
                        w = old_pend[1] ? 1 : 0;
                    end
                    m_owner    = (w == 1);
                    m_busy     = 1;
                    m_cur_push = m_push[w];
                    m_left     = lat_tab[m_k];
                    m_cur_val  = rd_tab[m_k];
                    m_k++;
                    grant_q.push_back('{m_push[w], m_data[w], cyc});
                end
                for (int p = 0; p < 2; p++) begin
                    if (trig[p] && !old_pend[p]) begin
                        m_pend[p] = 1;
                        m_push[p] = tpush[p];
                        m_data[p] = tdata[p];
                    end
                end
            end
        end
    end

    // Stack responder: answers each stk_trigger after its table latency, with random
    // junk on stk_read otherwise and occasional stray stk_done while nothing is outstanding.
    initial begin
        stk_done = 1'b0;
        stk_read = 32'd0;
        forever begin
            @(negedge clk);
            stk_done = 1'b0;
            stk_read = $urandom;
            if (!r_busy && stk_trigger) begin
                r_busy = 1;
                r_left = lat_tab[r_k];
                r_val  = rd_tab[r_k];
                r_k++;
            end
            if (r_busy) begin
                if (r_left == 0) begin
                    stk_done = 1'b1;
                    stk_read = r_val;
                    r_busy   = 0;
                end else begin
                    r_left--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                stk_done = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a grant or a completion.
    always @(negedge clk) begin
        grant_t g;
        done_t  d;
        int     port;
        if (cyc > 0) begin
            chk(busy == m_busy && owner == m_owner, "busy_owner",
                $sformatf("busy=%0b owner=%0b", busy, owner),
                $sformatf("busy=%0b owner=%0b", m_busy, m_owner));
            if (stk_trigger) begin
                wr_log.push_back(stk_write);
                if (grant_q.size() == 0) begin
                    chk(0, "grant_unexpected", $sformatf("stk_trigger at cycle %0d", cyc), "no grant");
                end else begin
                    g = grant_q.pop_front();
                    chk(stk_push == g.push && stk_write == g.wr && cyc == g.cyc, "grant",
                        $sformatf("push=%0b write=%h cycle=%0d", stk_push, stk_write, cyc),
                        $sformatf("push=%0b write=%h cycle=%0d", g.push, g.wr, g.cyc));
                end
            end
            if (a_done) a_done_cnt++;
            if (b_done) b_done_cnt++;
            if (a_done || b_done) begin
                port = b_done ? 1 : 0;
                chk(!(a_done && b_done), "done_exclusive", "a_done=1 b_done=1", "one at a time");
                if (done_q.size() == 0) begin
                    chk(0, "done_unexpected", $sformatf("port %0d done at cycle %0d", port, cyc), "no done");
                end else begin
                    d = done_q.pop_front();
                    chk(port == d.port && (port == 1 ? b_read : a_read) == d.rd && cyc == d.cyc
                        && owner == (port == 1), "done",
                        $sformatf("port=%0d read=%h cycle=%0d owner=%0b", port,
                                  port == 1 ? b_read : a_read, cyc, owner),
                        $sformatf("port=%0d read=%h cycle=%0d owner=%0b", d.port, d.rd, d.cyc, d.port == 1));
                end
            end
        end
    end

    task automatic drain();
        int n = 0;
        while ((grant_q.size() != 0 || done_q.size() != 0 || m_busy || m_pend[0] || m_pend[1] || r_busy)
               && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(n < 200, "drain_timeout", $sformatf("%0d cycles", n), "under 200 cycles");
        repeat (2) @(negedge clk);
    endtask

    task automatic idle_inputs();
        a_trigger = 1'b0;
        b_trigger = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] tie_exp [4];
        int a0, b0;
`ifdef STACK_ARB_ROUNDROBIN_EN
        tie_exp = '{32'd7, 32'd5, 32'd7, 32'd5};
`else
        tie_exp = '{32'd5, 32'd7, 32'd5, 32'd7};
`endif
        for (int i = 0; i < TAB; i++) begin
            lat_tab[i] = $urandom_range(0, 3);
            rd_tab[i]  = $urandom;
        end
        rst = 1'b1;
        a_trigger = 0; a_push = 0; a_write = 0;
        b_trigger = 0; b_push = 0; b_write = 0;
        @(negedge clk);
        chk({stk_trigger, stk_push, a_done, b_done, owner, busy} == 6'd0 && stk_write == 0
            && a_read == 0 && b_read == 0, "reset_state",
            $sformatf("trig=%0b push=%0b ad=%0b bd=%0b own=%0b busy=%0b wr=%h ar=%h br=%h",
                      stk_trigger, stk_push, a_done, b_done, owner, busy, stk_write, a_read, b_read),
            "all zero");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single push from A, stack answers in the ISSUE cycle.
        lat_tab[m_k] = 0;
        a0 = a_done_cnt; b0 = b_done_cnt;
        a_trigger = 1; a_push = 1; a_write = 32'h0000_002A;
        @(negedge clk);
        idle_inputs();
        drain();
        chk(a_done_cnt - a0 == 1 && b_done_cnt == b0, "single_push_dones",
            $sformatf("a=%0d b=%0d", a_done_cnt - a0, b_done_cnt - b0), "a=1 b=0");

        // Single pop from B with three WAIT cycles.
        lat_tab[m_k] = 3;
        rd_tab[m_k]  = 32'hFFFF_FFF6;
        b_trigger = 1; b_push = 0; b_write = 32'h1234_5678;
        @(negedge clk);
        idle_inputs();
        drain();
        chk(b_read == 32'hFFFF_FFF6 && owner == 1'b1, "single_pop",
            $sformatf("b_read=%h owner=%0b", b_read, owner), "b_read=fffffff6 owner=1");

        // Simultaneous triggers, twice, starting from a fresh reset.
        do_reset();
        wr_log.delete();
        for (int r = 0; r < 2; r++) begin
            lat_tab[m_k] = 0;
            lat_tab[m_k + 1] = 0;
            a_trigger = 1; a_push = 1; a_write = 32'd5;
            b_trigger = 1; b_push = 1; b_write = 32'd7;
            @(negedge clk);
            idle_inputs();
            drain();
        end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] got;
            got = (i < wr_log.size()) ? wr_log[i] : 32'hDEAD_BEEF;
            chk(got == tie_exp[i], $sformatf("tie_order[%0d]", i),
                $sformatf("%0d", got), $sformatf("%0d", tie_exp[i]));
        end

        // Retrigger while pending: the second request must be dropped.
        lat_tab[m_k] = 5;
        wr_log.delete();
        a0 = a_done_cnt;
        a_trigger = 1; a_push = 1; a_write = 32'd1;
        @(negedge clk);
        a_trigger = 0;
        @(negedge clk);
        a_trigger = 1; a_write = 32'd2;
        @(negedge clk);
        idle_inputs();
        drain();
        chk(wr_log.size() == 1 && wr_log[0] == 32'd1 && a_done_cnt - a0 == 1, "retrigger",
            $sformatf("pushes=%0d first=%h dones=%0d", wr_log.size(),
                      wr_log.size() > 0 ? wr_log[0] : 32'd0, a_done_cnt - a0),
            "pushes=1 first=00000001 dones=1");

        // Reset while in WAIT; the late stk_done must be ignored.
        lat_tab[m_k] = 4;
        a0 = a_done_cnt; b0 = b_done_cnt;
        a_trigger = 1; a_push = 0;
        @(negedge clk);
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drain();
        chk(a_done_cnt == a0 && b_done_cnt == b0 && busy == 0 && stk_trigger == 0, "reset_mid_wait",
            $sformatf("dones=%0d busy=%0b trig=%0b", a_done_cnt - a0 + b_done_cnt - b0, busy, stk_trigger),
            "dones=0 busy=0 trig=0");
        lat_tab[m_k] = 1;
        b_trigger = 1; b_push = 1; b_write = 32'hCAFE_0001;
        @(negedge clk);
        idle_inputs();
        drain();
        chk(b_done_cnt - b0 == 1, "after_reset_request",
            $sformatf("%0d", b_done_cnt - b0), "1");

        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            a_trigger = ($urandom_range(0, 2) == 0);
            a_push    = $urandom_range(0, 1) == 1;
            a_write   = $urandom;
            b_trigger = ($urandom_range(0, 2) == 0);
            b_push    = $urandom_range(0, 1) == 1;
            b_write   = $urandom;
            @(negedge clk);
        end
        idle_inputs();
        drain();
        chk(grant_q.size() == 0 && done_q.size() == 0, "queues_empty",
            $sformatf("grants=%0d dones=%0d", grant_q.size(), done_q.size()), "0 and 0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
